// File: rtl/interrupt_arbiter_if.sv
// Handler-side bus of the interrupt arbiter: request lines, mask/software
// controls, the accept/done handshake and the status outputs.
interface interrupt_arbiter_if;
  logic [7:0] irqIn;
  logic       maskWrite;
  logic [7:0] maskData;
  logic       globalEnable;
  logic       swReq;
  logic [2:0] swCode;
  logic       intAccept;
  logic       intDone;
  logic       interruptSignalOut;
  logic [3:0] interruptIndexOut;
  logic [7:0] pendingOut;
  logic [7:0] maskOut;
  logic       busyOut;

  modport master (
    output irqIn, maskWrite, maskData, globalEnable, swReq, swCode, intAccept, intDone,
    input  interruptSignalOut, interruptIndexOut, pendingOut, maskOut, busyOut
  );

  modport slave (
    input  irqIn, maskWrite, maskData, globalEnable, swReq, swCode, intAccept, intDone,
    output interruptSignalOut, interruptIndexOut, pendingOut, maskOut, busyOut
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// Non-nesting interrupt arbiter: 8 edge-triggered hardware lines (bit 0 highest)
// plus one software request, presented one at a time with an accept timeout.
module interrupt_arbiter #(
  parameter int unsigned ACCEPT_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  interrupt_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

  state_t     r_state;
  logic [7:0] r_irq_prev;
  logic       r_armed;
  logic [7:0] r_pending;
  logic       r_sw_pending;
  logic [2:0] r_sw_code;
  logic [7:0] r_mask;
  logic [3:0] r_sel;
  logic [3:0] r_index;
  logic       r_signal;
  logic       r_busy;
  logic [3:0] r_timeout;

  logic [7:0] w_rise;
  logic [7:0] w_active;
  logic [3:0] w_hw_idx;
  logic       w_hw_hit;
  logic       w_grant;
  logic [3:0] w_grant_idx;
  logic       w_accept;
  logic [7:0] w_clr_hw;
  logic       w_clr_sw;

  // r_armed suppresses edge detection on the first cycle after reset so a line
  // held high through release is only captured into history.
  assign w_rise   = r_armed ? (bus.irqIn & ~r_irq_prev) : 8'h00;
  assign w_active = r_pending & r_mask;

  always_comb begin
    w_hw_idx = 4'd0;
    w_hw_hit = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (w_active[i]) begin
        w_hw_idx = 4'(i);
        w_hw_hit = 1'b1;
      end
    end
  end

  assign w_grant     = (r_state == IDLE) && bus.globalEnable && (w_hw_hit || r_sw_pending);
  assign w_grant_idx = w_hw_hit ? w_hw_idx : {1'b1, r_sw_code};
  assign w_accept    = (r_state == REQUEST) && bus.intAccept;
  assign w_clr_hw    = (w_accept && !r_sel[3]) ? (8'b1 << r_sel[2:0]) : 8'h00;
  assign w_clr_sw    = w_accept && r_sel[3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_irq_prev   <= 8'h00;
      r_armed      <= 1'b0;
      r_pending    <= 8'h00;
      r_sw_pending <= 1'b0;
      r_sw_code    <= 3'd0;
      r_mask       <= 8'h00;
      r_sel        <= 4'd0;
      r_index      <= 4'd0;
      r_signal     <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 4'd0;
    end else begin
      r_armed    <= 1'b1;
      r_irq_prev <= bus.irqIn;
      // A new edge on the bit being cleared keeps it pending.
      r_pending  <= (r_pending & ~w_clr_hw) | w_rise;

      if (w_clr_sw) begin
        r_sw_pending <= 1'b0;
      end else if (bus.swReq && !r_sw_pending) begin
        r_sw_pending <= 1'b1;
        r_sw_code    <= bus.swCode;
      end

      if (bus.maskWrite) begin
        r_mask <= bus.maskData;
      end

      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state   <= REQUEST;
            r_sel     <= w_grant_idx;
            r_index   <= w_grant_idx;
            r_signal  <= 1'b1;
            r_timeout <= 4'd0;
          end
        end
        REQUEST: begin
          if (bus.intAccept) begin
            r_state  <= SERVICE;
            r_signal <= 1'b0;
            r_index  <= 4'd0;
            r_busy   <= 1'b1;
          end else if (r_timeout == 4'(ACCEPT_TIMEOUT - 1)) begin
            r_state   <= IDLE;
            r_signal  <= 1'b0;
            r_index   <= 4'd0;
            r_timeout <= 4'd0;
          end else begin
            r_timeout <= r_timeout + 4'd1;
          end
        end
        SERVICE: begin
          if (bus.intDone) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_signal <= 1'b0;
          r_index  <= 4'd0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interruptSignalOut = r_signal;
  assign bus.interruptIndexOut  = r_index;
  assign bus.pendingOut         = r_pending;
  assign bus.maskOut            = r_mask;
  assign bus.busyOut            = r_busy;

endmodule
